// File: rtl/fifo_byte_tx.sv
// Pops bytes from the FIFO read port and sends each one on tx as an 8N1 frame
// (start bit, 8 data bits LSB first, stop bit), CLKS_PER_BIT clocks per bit.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high; pop when enabled and the FIFO has data
// POP   | rd_en drops; FIFO is presenting the popped byte
// LATCH | byte captured into the shift register; start bit begins
// START | start bit (tx=0) held for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, each held CLKS_PER_BIT cycles
// STOP  | stop bit (tx=1); frame counted on exit
module fifo_byte_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(CLKS_PER_BIT - 1);

  state_t            state_q, state_d;
  logic [7:0]        tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              rd_en_q, rd_en_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [7:0]        count_q, count_d;
  logic              tick_done;
  logic              start_ok;

  assign tick_done = (tick_q == TICK_LAST);
  assign start_ok  = enable && !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_POP;
      S_POP:   state_d = S_LATCH;
      S_LATCH: state_d = S_START;
      S_START: if (tick_done) state_d = S_DATA;
      S_DATA:  if (tick_done && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (tick_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath; the tick counter
  // restarts at every bit boundary.
  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rd_en_d = 1'b0;
    tx_d    = tx_q;
    busy_d  = busy_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        tick_d = '0;
        if (start_ok) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_POP: begin
        rd_en_d = 1'b0;
      end
      S_LATCH: begin
        shreg_d = fifo_data;
        tx_d    = 1'b0;
        tick_d  = '0;
      end
      S_START: begin
        if (tick_done) begin
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      S_DATA: begin
        if (tick_done) begin
          tick_d = '0;
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      S_STOP: begin
        if (tick_done) begin
          tick_d  = '0;
          count_d = count_q + 8'd1;
          busy_d  = 1'b0;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        tick_d = '0;
      end
    endcase
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_fifo_byte_tx.sv
// Bench for fifo_byte_tx: two instances (4 and 1 clocks per bit), each fed by
// a FIFO model, with a serial decoder checking frames against a scoreboard.
module tb_fifo_byte_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en[2];
  logic       fe[2];
  logic       rd[2];
  logic       tx[2];
  logic       busy[2];
  logic [7:0] fd[2];
  logic [7:0] bc[2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int CPB = (gi == 0) ? 4 : 1;

    logic [7:0] fq[$];
    logic [9:0] sb[$];
    int rd_cnt   = 0;
    int frames   = 0;
    int starts   = 0;
    int gap      = 0;
    int gap_last = -1;

    fifo_byte_tx #(.CLKS_PER_BIT(CPB)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (en[gi]),
      .fifo_empty(fe[gi]),
      .fifo_data (fd[gi]),
      .fifo_rd_en(rd[gi]),
      .tx        (tx[gi]),
      .busy      (busy[gi]),
      .byte_count(bc[gi])
    );

    // FIFO read side: data appears well before the edge after rd_en is sampled
    initial begin
      fe[gi] = 1'b1;
      fd[gi] = 8'h00;
      forever begin
        @(negedge clk);
        if (rd[gi] === 1'b1) begin
          rd_cnt++;
          if (fq.size() > 0) fd[gi] = fq.pop_front();
        end
        fe[gi] = (fq.size() == 0);
      end
    end

    // Serial decoder: every bit must hold for exactly CPB samples
    initial begin
      logic       prev;
      logic       cur;
      logic       glitch;
      logic       aborted;
      logic [9:0] got;
      logic [9:0] exp;
      prev = 1'b1;
      cur  = 1'b1;
      forever begin
        @(negedge clk);
        if (reset !== 1'b1) begin
          prev = 1'b1;
          gap  = 0;
        end else if (prev && tx[gi] === 1'b0) begin
          starts++;
          gap_last = gap;
          glitch   = 1'b0;
          aborted  = 1'b0;
          got      = '0;
          for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
              if (b > 0 || c > 0) @(negedge clk);
              if (reset !== 1'b1) begin
                aborted = 1'b1;
              end else if (c == 0) begin
                cur = tx[gi];
                got = {cur, got[9:1]};
              end else if (tx[gi] !== cur) begin
                glitch = 1'b1;
              end
            end
          end
          if (!aborted) begin
            frames++;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: got 0x%0h expected no frame", got);
            end else begin
              exp = sb.pop_front();
              chk("frame", 32'({glitch, got}), 32'({1'b0, exp}));
            end
          end
          gap  = 0;
          prev = tx[gi];
        end else begin
          prev = tx[gi];
          if (tx[gi] === 1'b1) gap++;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    bit         wait_done;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int         pushed;
    logic       bad;
    logic [7:0] d;

    tbl[0] = '{8'hA5, 10'b1101001010, 1'b1, 8'd1};
    tbl[1] = '{8'h5E, 10'b1010111100, 1'b0, 8'd0};
    tbl[2] = '{8'h20, 10'b1001000000, 1'b1, 8'd3};

    reset = 1'b0;
    en[0] = 1'b0;
    en[1] = 1'b0;
    cyc(3);
    chk("rst_rd_en", 32'(rd[0]), 32'd0);
    chk("rst_tx", 32'(tx[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_count", 32'(bc[0]), 32'd0);
    chk("rst_tx_fast", 32'(tx[1]), 32'd1);
    reset = 1'b1;
    cyc(2);

    // enabled with an empty FIFO
    en[0] = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd[0] !== 1'b0) bad = 1'b1;
    end
    chk("empty_rd_pulses", g_dut[0].rd_cnt, 0);
    chk("empty_line_quiet", 32'(bad), 32'd0);
    chk("empty_count", 32'(bc[0]), 32'd0);

    // single byte, then two back-to-back bytes
    pushed = 0;
    for (int i = 0; i < 3; i++) begin
      g_dut[0].fq.push_back(tbl[i].data);
      g_dut[0].sb.push_back(tbl[i].frame);
      pushed++;
      if (tbl[i].wait_done) begin
        for (int k = 0; k < 2000 && g_dut[0].frames < pushed; k++) cyc(1);
        cyc(2);
        chk("tbl_frames", g_dut[0].frames, pushed);
        chk("tbl_count", 32'(bc[0]), 32'(tbl[i].exp_cnt));
        chk("tbl_busy", 32'(busy[0]), 32'd0);
      end
    end
    chk("tbl_rd_pulses", g_dut[0].rd_cnt, 3);
    chk("b2b_gap", g_dut[0].gap_last, 3);

    // enable dropped during data bit 3; a second byte must stay in the FIFO
    g_dut[0].fq.push_back(8'h12);
    g_dut[0].fq.push_back(8'h77);
    g_dut[0].sb.push_back(10'b1000100100);
    for (int k = 0; k < 200 && g_dut[0].starts < 4; k++) cyc(1);
    chk("en_drop_started", g_dut[0].starts, 4);
    cyc(17);
    en[0] = 1'b0;
    for (int k = 0; k < 200 && g_dut[0].frames < 4; k++) cyc(1);
    cyc(20);
    chk("en_drop_frames", g_dut[0].frames, 4);
    chk("en_drop_rd_pulses", g_dut[0].rd_cnt, 4);
    chk("en_drop_count", 32'(bc[0]), 32'd4);
    chk("en_drop_busy", 32'(busy[0]), 32'd0);
    chk("en_drop_left", g_dut[0].fq.size(), 1);
    g_dut[0].fq.delete();
    cyc(2);

    // asynchronous reset in the middle of a frame
    en[0] = 1'b1;
    g_dut[0].fq.push_back(8'h98);
    for (int k = 0; k < 200 && g_dut[0].starts < 5; k++) cyc(1);
    chk("rst_mid_started", g_dut[0].starts, 5);
    cyc(20);
    reset = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx[0]), 32'd1);
    chk("rst_mid_busy", 32'(busy[0]), 32'd0);
    chk("rst_mid_rd_en", 32'(rd[0]), 32'd0);
    chk("rst_mid_count", 32'(bc[0]), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(40);
    chk("post_rst_rd_pulses", g_dut[0].rd_cnt, 5);
    chk("post_rst_starts", g_dut[0].starts, 5);
    chk("post_rst_tx", 32'(tx[0]), 32'd1);
    chk("post_rst_count", 32'(bc[0]), 32'd0);

    // one clock per bit, 257 frames to wrap the counter
    en[1] = 1'b1;
    for (int i = 0; i < 257; i++) begin
      d = 8'(i * 37 + 5);
      g_dut[1].fq.push_back(d);
      g_dut[1].sb.push_back({1'b1, d, 1'b0});
    end
    for (int k = 0; k < 5000 && g_dut[1].frames < 255; k++) cyc(1);
    chk("wrap_count_255", 32'(bc[1]), 32'd255);
    for (int k = 0; k < 100 && g_dut[1].frames < 256; k++) cyc(1);
    chk("wrap_count_0", 32'(bc[1]), 32'd0);
    for (int k = 0; k < 100 && g_dut[1].frames < 257; k++) cyc(1);
    chk("wrap_count_1", 32'(bc[1]), 32'd1);
    cyc(20);
    chk("fast_frames", g_dut[1].frames, 257);
    chk("fast_rd_pulses", g_dut[1].rd_cnt, 257);
    chk("fast_gap", g_dut[1].gap_last, 3);
    chk("fast_sb_drained", g_dut[1].sb.size(), 0);
    chk("fast_busy", 32'(busy[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_byte_tx.md
Name: fifo_byte_tx

Overview:
- Read-side consumer for the team's byte-wide FIFO buffer.
- Pops one byte at a time over the FIFO read port (rd_en/empty/data_out) and transmits it on a single-wire serial line as an 8N1 frame: start bit, 8 data bits LSB first, stop bit.
- Sits between the FIFO read port and an off-block serial pin.
- Single clock domain, shared with the FIFO read clock.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255.
- DATA_W, 8, data width; fixed at 8, present for documentation only.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO read data; valid the cycle after fifo_rd_en is sampled high.
- fifo_rd_en  output  1  one-cycle pop request to FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high from pop issue to end of stop bit.
- byte_count  output  8  frames completed; wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: fifo_rd_en=0, tx=1, busy=0, byte_count=0.
  - Internal: state=IDLE, bit and tick counters=0.
  - A byte popped before reset is discarded; no partial frame resumes after reset release.
- All outputs are registered.
- States: IDLE, POP, LATCH, START, DATA, STOP.
- IDLE:
  - At an edge with enable=1 and fifo_empty=0: fifo_rd_en<=1, busy<=1, go POP.
  - Otherwise stay in IDLE; tx=1, busy=0.
- POP: fifo_rd_en<=0, go LATCH. Exactly one rd_en cycle per frame.
- LATCH: shift register<=fifo_data, tx<=0, tick=0, go START.
- START: tx held 0 for CLKS_PER_BIT cycles, then tx<=shreg[0], bit index=0, go DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first, shifting right.
  - After bit 7's period: tx<=1, go STOP.
- STOP: tx held 1 for CLKS_PER_BIT cycles, then byte_count<=byte_count+1 (mod 256), busy<=0, go IDLE.
- Timing:
  - Condition seen at edge N: fifo_rd_en high N..N+1, tx falls at edge N+2.
  - Frame occupies 10*CLKS_PER_BIT cycles from tx fall to the end of the stop bit.
  - Back-to-back frames: tx stays high for the stop bit plus 3 cycles (IDLE, POP, LATCH) before the next start bit.
- Boundary rules:
  - fifo_empty is ignored outside IDLE; the block never pops while busy.
  - If fifo_empty rises during the POP cycle, the popped byte is still transmitted.
  - enable deasserted mid-frame: the current frame completes, then the block stays in IDLE.
  - CLKS_PER_BIT=1: each bit lasts exactly one cycle.
  - The tick counter is sized for 255 and resets at every bit boundary.
  - byte_count is never cleared except by reset.

Test Plan:
1. CLKS_PER_BIT=4; FIFO holds 0xA5, enable=1 → one rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; byte_count=1; busy low after stop.
2. FIFO empty, enable=1 for 100 cycles → fifo_rd_en never high; tx=1, busy=0, byte_count=0.
3. FIFO holds 0x5E then 0x20 → exactly two rd_en pulses; frames carry 0x5E then 0x20; tx high for 4+3 cycles between them; byte_count=2.
4. enable dropped during DATA bit 3 of 0x12 → frame completes with correct bits and stop; no further rd_en; byte_count=1.
5. reset asserted mid-DATA of 0x98 → tx=1, busy=0, fifo_rd_en=0 immediately without a clock edge; after release, no stray frame until a new pop.
6. CLKS_PER_BIT=1; 257 bytes streamed → each frame 10 cycles; byte_count reads 255 then 0 then 1.
